// File: rtl/pc_ifid_stage.sv
// pc_ifid_stage: program counter and IF/ID pipeline register with a small
// BOOT/RUN/STALL controller. The PC addresses instruction memory directly
// (combinational read) and the fetched word is latched into IF/ID one edge later.
// Optional feature macro: PC_IFID_STALL_COUNTER_EN enables a saturating
// 16-bit counter of cycles in which the PC was held by the hazard unit.
module pc_ifid_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I_PC_WRITE,
    input  logic        I_IFID_WRITE,
    input  logic        I_BRANCH_TAKEN,
    input  logic [31:0] I_BRANCH_TARGET,
    input  logic [31:0] I_IMEM_DATA,
    output logic [31:0] O_IMEM_ADDR,
    output logic [31:0] O_IFID_INSTR,
    output logic [31:0] O_IFID_PC4,
    output logic        O_IFID_VALID,
    output logic [4:0]  O_IFID_RS,
    output logic [4:0]  O_IFID_RT,
    output logic        O_STALLED,
    output logic [15:0] O_STALL_COUNT
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_pc;
    logic        w_active;

    // PC+4 wraps naturally modulo 2^32; branch targets are forced word-aligned.
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_branch_pc = {I_BRANCH_TARGET[31:2], 2'b00};
    // BOOT is a one-cycle settle: nothing but the state register moves.
    assign w_active    = (r_state != BOOT);

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: STALL only when both enables drop, leave only when both return.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     if (!I_PC_WRITE && !I_IFID_WRITE) w_state_next = STALL;
            STALL:   if (I_PC_WRITE && I_IFID_WRITE)   w_state_next = RUN;
            default: w_state_next = BOOT;
        endcase
    end

    // PC update: hold beats redirect, redirect beats sequential increment.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc <= RESET_PC;
        end else if (w_active && I_PC_WRITE) begin
            r_pc <= I_BRANCH_TAKEN ? w_branch_pc : w_pc_plus4;
        end
    end

    // IF/ID update: hold beats flush, flush beats load of the fetched word.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ifid_instr <= 32'h0000_0000;
            r_ifid_pc4   <= 32'h0000_0000;
            r_ifid_valid <= 1'b0;
        end else if (w_active && I_IFID_WRITE) begin
            if (I_BRANCH_TAKEN) begin
                r_ifid_instr <= 32'h0000_0000;
                r_ifid_pc4   <= 32'h0000_0000;
                r_ifid_valid <= 1'b0;
            end else begin
                r_ifid_instr <= I_IMEM_DATA;
                r_ifid_pc4   <= w_pc_plus4;
                r_ifid_valid <= 1'b1;
            end
        end
    end

`ifdef PC_IFID_STALL_COUNTER_EN
    logic [15:0] r_stall_count;

    // Count held-PC cycles outside BOOT, saturating; only reset clears it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_stall_count <= 16'h0000;
        end else if (w_active && !I_PC_WRITE && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign O_STALL_COUNT = r_stall_count;
`else
    assign O_STALL_COUNT = 16'h0000;
`endif

    assign O_IMEM_ADDR  = r_pc;
    assign O_IFID_INSTR = r_ifid_instr;
    assign O_IFID_PC4   = r_ifid_pc4;
    assign O_IFID_VALID = r_ifid_valid;
    // Register fields are masked when the slot is a bubble so the hazard unit sees no sources.
    assign O_IFID_RS    = r_ifid_valid ? r_ifid_instr[25:21] : 5'd0;
    assign O_IFID_RT    = r_ifid_valid ? r_ifid_instr[20:16] : 5'd0;
    assign O_STALLED    = (r_state == STALL);

endmodule

// File: tb/tb_pc_ifid_stage.sv
// Directed testbench for pc_ifid_stage (RESET_PC = 0x00400000).
// Expected stall counts follow PC_IFID_STALL_COUNTER_EN if defined.
module tb_pc_ifid_stage;

    logic        CLK;
    logic        RESET;
    logic        I_PC_WRITE;
    logic        I_IFID_WRITE;
    logic        I_BRANCH_TAKEN;
    logic [31:0] I_BRANCH_TARGET;
    logic [31:0] I_IMEM_DATA;
    logic [31:0] O_IMEM_ADDR;
    logic [31:0] O_IFID_INSTR;
    logic [31:0] O_IFID_PC4;
    logic        O_IFID_VALID;
    logic [4:0]  O_IFID_RS;
    logic [4:0]  O_IFID_RT;
    logic        O_STALLED;
    logic [15:0] O_STALL_COUNT;

    int n_checks = 0;
    int n_errors = 0;

    pc_ifid_stage #(.RESET_PC(32'h0040_0000)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .I_PC_WRITE      (I_PC_WRITE),
        .I_IFID_WRITE    (I_IFID_WRITE),
        .I_BRANCH_TAKEN  (I_BRANCH_TAKEN),
        .I_BRANCH_TARGET (I_BRANCH_TARGET),
        .I_IMEM_DATA     (I_IMEM_DATA),
        .O_IMEM_ADDR     (O_IMEM_ADDR),
        .O_IFID_INSTR    (O_IFID_INSTR),
        .O_IFID_PC4      (O_IFID_PC4),
        .O_IFID_VALID    (O_IFID_VALID),
        .O_IFID_RS       (O_IFID_RS),
        .O_IFID_RT       (O_IFID_RT),
        .O_STALLED       (O_STALLED),
        .O_STALL_COUNT   (O_STALL_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] exp_cnt(input logic [15:0] n);
`ifdef PC_IFID_STALL_COUNTER_EN
        return n;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid,
                            input logic [4:0] rs, input logic [4:0] rt);
        chk({tag, ".pc"},    O_IMEM_ADDR, pc);
        chk({tag, ".instr"}, O_IFID_INSTR, instr);
        chk({tag, ".pc4"},   O_IFID_PC4, pc4);
        chk({tag, ".valid"}, {31'd0, O_IFID_VALID}, {31'd0, valid});
        chk({tag, ".rs"},    {27'd0, O_IFID_RS}, {27'd0, rs});
        chk({tag, ".rt"},    {27'd0, O_IFID_RT}, {27'd0, rt});
    endtask

    initial begin
        RESET           = 1'b1;
        I_PC_WRITE      = 1'b1;
        I_IFID_WRITE    = 1'b1;
        I_BRANCH_TAKEN  = 1'b0;
        I_BRANCH_TARGET = 32'h0;
        I_IMEM_DATA     = 32'h8C22_0004;

        // Reset values before any clock edge
        #2;
        chk_ifid("rst0", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        chk("rst0.stalled", {31'd0, O_STALLED}, 32'd0);
        chk("rst0.count", {16'd0, O_STALL_COUNT}, 32'd0);

        step();
        RESET = 1'b0;

        // BOOT edge: PC held, IF/ID not loaded
        step();
        chk_ifid("boot", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);

        // First fetch: lw-style word, rs=1 rt=2
        step();
        chk_ifid("fetch1", 32'h0040_0004, 32'h8C22_0004, 32'h0040_0004, 1'b1, 5'd1, 5'd2);
        chk("fetch1.stalled", {31'd0, O_STALLED}, 32'd0);

        // Three-cycle stall; a branch in the middle must be ignored
        I_PC_WRITE      = 1'b0;
        I_IFID_WRITE    = 1'b0;
        I_IMEM_DATA     = 32'h0143_4820;
        step();
        chk_ifid("stall1", 32'h0040_0004, 32'h8C22_0004, 32'h0040_0004, 1'b1, 5'd1, 5'd2);
        chk("stall1.stalled", {31'd0, O_STALLED}, 32'd1);
        I_BRANCH_TAKEN  = 1'b1;
        I_BRANCH_TARGET = 32'h0000_0200;
        step();
        chk_ifid("stall2br", 32'h0040_0004, 32'h8C22_0004, 32'h0040_0004, 1'b1, 5'd1, 5'd2);
        chk("stall2.stalled", {31'd0, O_STALLED}, 32'd1);
        I_BRANCH_TAKEN  = 1'b0;
        step();
        chk("stall3.pc", O_IMEM_ADDR, 32'h0040_0004);
        chk("stall3.stalled", {31'd0, O_STALLED}, 32'd1);
        chk("stall3.count", {16'd0, O_STALL_COUNT}, {16'd0, exp_cnt(16'd3)});

        // Release: fetch 0x01434820 (rs=10, rt=3) at 0x00400004
        I_PC_WRITE   = 1'b1;
        I_IFID_WRITE = 1'b1;
        step();
        chk_ifid("resume", 32'h0040_0008, 32'h0143_4820, 32'h0040_0008, 1'b1, 5'd10, 5'd3);
        chk("resume.stalled", {31'd0, O_STALLED}, 32'd0);

        // Taken branch: aligned redirect and flush
        I_BRANCH_TAKEN  = 1'b1;
        I_BRANCH_TARGET = 32'h0000_0103;
        step();
        chk_ifid("branch", 32'h0000_0100, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);

        // PC held, IF/ID loads: independent enables, stays in RUN
        I_BRANCH_TAKEN = 1'b0;
        I_PC_WRITE     = 1'b0;
        I_IMEM_DATA    = 32'h2108_FFFF;
        step();
        chk_ifid("pconly", 32'h0000_0100, 32'h2108_FFFF, 32'h0000_0104, 1'b1, 5'd8, 5'd8);
        chk("pconly.stalled", {31'd0, O_STALLED}, 32'd0);
        chk("pconly.count", {16'd0, O_STALL_COUNT}, {16'd0, exp_cnt(16'd4)});

        // Branch to top word, then wrap through zero
        I_PC_WRITE      = 1'b1;
        I_BRANCH_TAKEN  = 1'b1;
        I_BRANCH_TARGET = 32'hFFFF_FFFF;
        step();
        chk("top.pc", O_IMEM_ADDR, 32'hFFFF_FFFC);
        I_BRANCH_TAKEN = 1'b0;
        I_IMEM_DATA    = 32'h0000_0020;
        step();
        chk_ifid("wrap", 32'h0000_0000, 32'h0000_0020, 32'h0000_0000, 1'b1, 5'd0, 5'd0);

        // Enter stall, then reset asynchronously with a branch pending
        I_PC_WRITE   = 1'b0;
        I_IFID_WRITE = 1'b0;
        step();
        chk("prerst.stalled", {31'd0, O_STALLED}, 32'd1);
        chk("prerst.count", {16'd0, O_STALL_COUNT}, {16'd0, exp_cnt(16'd5)});
        I_BRANCH_TAKEN  = 1'b1;
        I_BRANCH_TARGET = 32'h0000_0300;
        #2;
        RESET = 1'b1;
        #1;
        chk_ifid("arst", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        chk("arst.stalled", {31'd0, O_STALLED}, 32'd0);
        chk("arst.count", {16'd0, O_STALL_COUNT}, 32'd0);

        // After release, BOOT ignores the still-asserted branch
        step();
        RESET        = 1'b0;
        I_PC_WRITE   = 1'b1;
        I_IFID_WRITE = 1'b1;
        step();
        chk_ifid("boot2", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        I_BRANCH_TAKEN = 1'b0;
        I_IMEM_DATA    = 32'h8C22_0004;
        step();
        chk_ifid("fetch2", 32'h0040_0004, 32'h8C22_0004, 32'h0040_0004, 1'b1, 5'd1, 5'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_ifid_stage.md
PC_IFID_STAGE -- requirements
Module: pc_ifid_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port I_PC_WRITE  input  1  PC update enable from the hazard detection unit; 0 holds PC.
REQ-005 SHALL have port I_IFID_WRITE  input  1  IF/ID register enable from the hazard detection unit; 0 holds IF/ID.
REQ-006 SHALL have port I_BRANCH_TAKEN  input  1  redirect request from ID; also flushes IF/ID.
REQ-007 SHALL have port I_BRANCH_TARGET  input  32  redirect address.
REQ-008 SHALL have port I_IMEM_DATA  input  32  instruction read combinationally at O_IMEM_ADDR.
REQ-009 SHALL have port O_IMEM_ADDR  output  32  current PC.
REQ-010 SHALL have port O_IFID_INSTR  output  32  latched instruction.
REQ-011 SHALL have port O_IFID_PC4  output  32  latched PC+4.
REQ-012 SHALL have port O_IFID_VALID  output  1  IF/ID holds a real instruction.
REQ-013 SHALL have ports O_IFID_RS and O_IFID_RT  output  5 each  instr[25:21] and instr[20:16] for the hazard unit; 0 when O_IFID_VALID=0.
REQ-014 SHALL have port O_STALLED  output  1  high while in state STALL.
REQ-015 SHALL have port O_STALL_COUNT  output  16  stall-cycle counter (see Configuration).

Function
REQ-016 SHALL implement states BOOT, RUN, STALL; RESET forces BOOT.
REQ-017 BOOT SHALL last exactly one cycle: PC held, IF/ID not loaded, then RUN unconditionally.
REQ-018 RUN -> STALL when I_PC_WRITE=0 and I_IFID_WRITE=0; STALL -> RUN when both are 1; other combinations SHALL stay in the current state.
REQ-019 In RUN/STALL, PC priority: I_PC_WRITE=0 holds PC; else I_BRANCH_TAKEN=1 loads {I_BRANCH_TARGET[31:2],2'b00}; else PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 In RUN/STALL, IF/ID priority: I_IFID_WRITE=0 holds all IF/ID outputs, flush included; else I_BRANCH_TAKEN=1 loads INSTR=0, PC4=0, VALID=0; else loads INSTR=I_IMEM_DATA, PC4=PC+4, VALID=1.
REQ-021 Fetch latency SHALL be one cycle: the instruction at PC appears on O_IFID_INSTR the edge after it is addressed.
REQ-022 I_PC_WRITE and I_IFID_WRITE SHALL be honoured independently; a branch presented while I_PC_WRITE=0 is ignored and must be re-presented.
REQ-023 O_IMEM_ADDR SHALL equal the PC register with no combinational path from inputs.

Reset
REQ-024 On RESET assertion, immediately: PC=RESET_PC, O_IFID_INSTR=0, O_IFID_PC4=0, O_IFID_VALID=0, state=BOOT, O_STALLED=0, O_STALL_COUNT=0.
REQ-025 Reset asserted mid-stall or mid-branch SHALL discard all pending state; no partial update may survive.

Configuration
REQ-026 Macro PC_IFID_STALL_COUNTER_EN, when defined: O_STALL_COUNT increments by 1 each cycle in RUN or STALL with I_PC_WRITE=0, saturating at 16'hFFFF, cleared only by RESET.
REQ-027 Without PC_IFID_STALL_COUNTER_EN: O_STALL_COUNT SHALL be tied to 16'h0000 and no counter flops synthesised.

Verification
REQ-028 Reset release, RESET_PC=32'h0040_0000, enables 1, IMEM returns 32'h8C22_0004 -> BOOT one cycle at 0x00400000; next edge O_IFID_INSTR=32'h8C22_0004, PC4=0x00400004, RS=1, RT=2, VALID=1; PC=0x00400004.
REQ-029 Both enables 0 for 3 cycles -> PC and IF/ID frozen, O_STALLED=1 for 3 cycles, O_STALL_COUNT=3 (macro defined) or 0 (undefined).
REQ-030 I_BRANCH_TAKEN=1, target 32'h0000_0103 -> next PC=0x00000100, VALID=0, INSTR=0, RS=RT=0.
REQ-031 I_BRANCH_TAKEN=1 with I_PC_WRITE=0, I_IFID_WRITE=0 -> no redirect, no flush, all state held.
REQ-032 PC=32'hFFFF_FFFC, enables 1 -> PC=0, O_IFID_PC4=0; RESET asserted mid-stall -> outputs per REQ-024 without waiting for CLK.
